ref_block_reader: RTL and testbench
===================================

REF_BLOCK_READER -- requirements
Module: ref_block_reader

Interface
REQ-001 Parameter REF_LENGTH, default 128, bases per reference block (2 bits/base; block width 2*REF_LENGTH).
REQ-002 Parameter FIFO_DEPTH, default 4, power of two >= 2, return-data buffer depth in blocks.
REQ-003 clk  input  1  engine clock; the only clock; all logic on rising edge.
REQ-004 rst  input  1  system reset, asynchronous, active-high.
REQ-005 ref_addr_in  input  25  DRAM block address of first reference block.
REQ-006 ref_length_in  input  25  number of blocks to read.
REQ-007 ref_info_valid_in  input  1  request valid.
REQ-008 ref_info_rdy_out  output  1  request accepted when high together with valid.
REQ-009 dram_cmd_addr_out  output  25  DRAM read block address.
REQ-010 dram_cmd_valid_out  output  1  read command valid.
REQ-011 dram_cmd_rdy_in  input  1  DRAM accepts command when high together with valid.
REQ-012 dram_data_in  input  2*REF_LENGTH  read return data, in command order.
REQ-013 dram_data_valid_in  input  1  return data valid; no backpressure on this path.
REQ-014 ref_seq_block_out  output  2*REF_LENGTH  reference block to engine.
REQ-015 ref_seq_block_valid_out  output  1  block valid.
REQ-016 ref_seq_block_rdy_in  input  1  engine consumes block when high together with valid.
REQ-017 ref_done_out  output  1  one-cycle pulse when a request has been fully delivered.

Function
REQ-018 The block SHALL implement states IDLE, ISSUE, DRAIN.
REQ-019 IDLE: ref_info_rdy_out SHALL be 1; ref_info_rdy_out SHALL be 0 in ISSUE and DRAIN.
REQ-020 On IDLE handshake with ref_length_in != 0: latch addr and length into cur_addr and remaining; next state ISSUE.
REQ-021 On IDLE handshake with ref_length_in == 0: stay IDLE, issue nothing, pulse ref_done_out the following cycle.
REQ-022 outstanding = commands accepted minus data beats returned; credits = FIFO_DEPTH - fifo_count - outstanding.
REQ-023 ISSUE: dram_cmd_valid_out SHALL be 1 iff credits > 0; dram_cmd_addr_out SHALL equal cur_addr.
REQ-024 Once asserted, dram_cmd_valid_out and dram_cmd_addr_out SHALL hold until accepted.
REQ-025 Each accepted command: cur_addr += 1 (modulo 2^25, 0x1FFFFFF wraps to 0), remaining -= 1, outstanding += 1.
REQ-026 Command accepted with remaining == 1: next state DRAIN; dram_cmd_valid_out low from next cycle.
REQ-027 First command SHALL be valid the cycle after request acceptance (latency 1).
REQ-028 Each dram_data_valid_in beat SHALL be written to FIFO and outstanding decremented the same edge.
REQ-029 A beat with outstanding == 0 SHALL be dropped; FIFO and counters unchanged.
REQ-030 FIFO SHALL be show-ahead: ref_seq_block_valid_out = (fifo_count != 0), ref_seq_block_out = head entry.
REQ-031 Returned beat SHALL be visible on ref_seq_block_out the cycle after dram_data_valid_in.
REQ-032 Pop on valid & rdy; push, pop and command accept in one cycle SHALL all take effect with correct counts.
REQ-033 Credit rule SHALL guarantee no FIFO overflow; fifo_count + outstanding never exceeds FIFO_DEPTH.
REQ-034 DRAIN: when outstanding == 0 and fifo_count == 0 (or final pop reaches that), pulse ref_done_out for one cycle and go IDLE.
REQ-035 Blocks SHALL reach the engine in address order with no loss or duplication.

Reset
REQ-036 rst high SHALL immediately force IDLE and clear FIFO, outstanding, cur_addr, remaining.
REQ-037 During and after reset: ref_info_rdy_out=1 once in IDLE; dram_cmd_valid_out, ref_seq_block_valid_out, ref_done_out=0; dram_cmd_addr_out, ref_seq_block_out=0.
REQ-038 Reset mid-request SHALL abandon it; DRAM interface is reset by the same rst, so no stale returns are expected.

Verification
REQ-039 addr=0x100, length=3, cmd_rdy=1, data 2 cycles after command, engine rdy=1 -> commands 0x100,0x101,0x102; three blocks in order; one ref_done_out.
REQ-040 length=8, FIFO_DEPTH=4, engine rdy=0 -> exactly 4 commands issued then cmd_valid stays 0; raise rdy -> remaining 4 issued; 8 blocks delivered in order.
REQ-041 addr=0x1FFFFFF, length=2 -> command addresses 0x1FFFFFF then 0x0000000.
REQ-042 length=0 -> no command, ref_done_out pulse one cycle later, ref_info_rdy_out stays 1.
REQ-043 Same-cycle push, pop and command accept with fifo_count=2 -> fifo_count stays 2, outstanding unchanged, no loss.
REQ-044 rst asserted mid-ISSUE with 2 blocks buffered -> all outputs zero immediately, ref_info_rdy_out=1; new request then completes normally.

Source files
------------

// File: rtl/ref_block_reader.sv
// Reference block reader: turns a (start address, block count) request into a
// stream of DRAM read commands and forwards the returned blocks, in order, to the
// engine through a small show-ahead buffer. Commands are only issued when the
// buffer is guaranteed to have room for their return data.
module ref_block_reader #(
    parameter int unsigned REF_LENGTH = 128,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    // Request from the engine
    input  logic [24:0]             ref_addr_in,
    input  logic [24:0]             ref_length_in,
    input  logic                    ref_info_valid_in,
    output logic                    ref_info_rdy_out,
    // DRAM read command
    output logic [24:0]             dram_cmd_addr_out,
    output logic                    dram_cmd_valid_out,
    input  logic                    dram_cmd_rdy_in,
    // DRAM read return (no backpressure)
    input  logic [2*REF_LENGTH-1:0] dram_data_in,
    input  logic                    dram_data_valid_in,
    // Block stream to the engine
    output logic [2*REF_LENGTH-1:0] ref_seq_block_out,
    output logic                    ref_seq_block_valid_out,
    input  logic                    ref_seq_block_rdy_in,
    output logic                    ref_done_out
);

    localparam int unsigned BlockW = 2 * REF_LENGTH;
    localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW   = PtrW + 1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain
    } state_e;

    state_e            state_q, state_d;
    logic [24:0]       cur_addr_q, cur_addr_d;
    logic [24:0]       remaining_q, remaining_d;
    logic [CntW-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [CntW-1:0]   outstanding_q, outstanding_d;
    logic [CntW-1:0]   credits;
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [BlockW-1:0] mem_q [FIFO_DEPTH];
    logic              done_q, done_d;

    logic req_fire;
    logic cmd_fire;
    logic push;
    logic pop;

    // Handshakes, credit accounting and output decode.
    always_comb begin
        // Slots not yet claimed by buffered data or by commands still in flight.
        credits                 = CntW'(FIFO_DEPTH) - fifo_cnt_q - outstanding_q;
        ref_info_rdy_out        = (state_q == StIdle);
        dram_cmd_valid_out      = (state_q == StIssue) && (credits != '0);
        dram_cmd_addr_out       = cur_addr_q;
        ref_seq_block_valid_out = (fifo_cnt_q != '0);
        ref_seq_block_out       = mem_q[rd_ptr_q];
        ref_done_out            = done_q;

        req_fire = ref_info_valid_in && ref_info_rdy_out;
        cmd_fire = dram_cmd_valid_out && dram_cmd_rdy_in;
        // A beat with nothing in flight is stray and is discarded.
        push     = dram_data_valid_in && (outstanding_q != '0);
        pop      = ref_seq_block_valid_out && ref_seq_block_rdy_in;

        fifo_cnt_d    = fifo_cnt_q + CntW'(push) - CntW'(pop);
        outstanding_d = outstanding_q + CntW'(cmd_fire) - CntW'(push);
    end

    // Next-state logic: request capture, command sequencing, completion.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_fire) begin
                    if (ref_length_in == 25'd0) begin
                        done_d = 1'b1;
                    end else begin
                        cur_addr_d  = ref_addr_in;
                        remaining_d = ref_length_in;
                        state_d     = StIssue;
                    end
                end
            end
            StIssue: begin
                if (cmd_fire) begin
                    // 25-bit add wraps 0x1FFFFFF to 0 naturally.
                    cur_addr_d  = cur_addr_q + 25'd1;
                    remaining_d = remaining_q - 25'd1;
                    if (remaining_q == 25'd1) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Finish on the edge that empties both the buffer and the return pipe.
                if ((fifo_cnt_d == '0) && (outstanding_d == '0)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cur_addr_q    <= '0;
            remaining_q   <= '0;
            fifo_cnt_q    <= '0;
            outstanding_q <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            remaining_q   <= remaining_d;
            fifo_cnt_q    <= fifo_cnt_d;
            outstanding_q <= outstanding_d;
            done_q        <= done_d;
        end
    end

    // Return-data buffer storage and pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= dram_data_in;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ref_block_reader.sv
// Bench for ref_block_reader: a DRAM model with in-order variable-latency returns,
// a request-level reference model (expected address list and block stream), a
// vector table, randomized requests and directed multi-cycle corner cases.
module tb_ref_block_reader;

    localparam int unsigned REF_LEN = 128;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned BW      = 2 * REF_LEN;

    logic          clk = 1'b0;
    logic          rst;
    logic [24:0]   ref_addr_in;
    logic [24:0]   ref_length_in;
    logic          ref_info_valid_in;
    logic          ref_info_rdy_out;
    logic [24:0]   dram_cmd_addr_out;
    logic          dram_cmd_valid_out;
    logic          dram_cmd_rdy_in;
    logic [BW-1:0] dram_data_in;
    logic          dram_data_valid_in;
    logic [BW-1:0] ref_seq_block_out;
    logic          ref_seq_block_valid_out;
    logic          ref_seq_block_rdy_in;
    logic          ref_done_out;

    ref_block_reader #(
        .REF_LENGTH(REF_LEN),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .ref_addr_in            (ref_addr_in),
        .ref_length_in          (ref_length_in),
        .ref_info_valid_in      (ref_info_valid_in),
        .ref_info_rdy_out       (ref_info_rdy_out),
        .dram_cmd_addr_out      (dram_cmd_addr_out),
        .dram_cmd_valid_out     (dram_cmd_valid_out),
        .dram_cmd_rdy_in        (dram_cmd_rdy_in),
        .dram_data_in           (dram_data_in),
        .dram_data_valid_in     (dram_data_valid_in),
        .ref_seq_block_out      (ref_seq_block_out),
        .ref_seq_block_valid_out(ref_seq_block_valid_out),
        .ref_seq_block_rdy_in   (ref_seq_block_rdy_in),
        .ref_done_out           (ref_done_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] addr;
        int          len;
        int          cmd_pct;
        int          eng_pct;
        int          lmin;
        int          lmax;
        logic [24:0] exp_last;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // Environment / model state
    int          cyc = 0;
    int          cmd_pct = 100, eng_pct = 100, lat_min = 1, lat_max = 1;
    bit          eng_hold = 0, spurious = 0, req_go = 0;
    logic [24:0] req_addr = '0, req_len = '0;
    logic [24:0] exp_addr_q[$];
    logic [24:0] exp_blk_q[$];
    logic [24:0] ret_addr_q[$];
    int          ret_due_q[$];
    int          last_due = 0, inflight = 0;
    int          n_cmd = 0, n_blk = 0, n_done = 0;
    int          req_cyc = -1, first_valid_cyc = -1, done_cyc = -1;
    bit          saw_valid = 0, prev_wait = 0;
    logic [24:0] prev_addr = '0, last_cmd_addr = '0;

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_vec(input string name, input logic [BW-1:0] act,
                             input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // DRAM contents: each block is a distinct function of its address.
    function automatic logic [BW-1:0] blk_of(input logic [24:0] a);
        logic [BW-1:0] d;
        for (int i = 0; i < int'(BW / 32); i++) begin
            d[i*32 +: 32] = {a[6:0], a} ^ (32'h9E37_79B9 * 32'(i + 1));
        end
        return d;
    endfunction

    // One cycle: at the falling edge drive inputs, then score the handshakes that
    // the following rising edge will perform.
    task automatic tick();
        int lat;
        int due;
        @(negedge clk);
        cyc++;
        dram_cmd_rdy_in      = ($urandom_range(99) < cmd_pct);
        ref_seq_block_rdy_in = !eng_hold && ($urandom_range(99) < eng_pct);
        ref_info_valid_in    = req_go;
        ref_addr_in          = req_addr;
        ref_length_in        = req_len;
        if (ret_due_q.size() != 0 && ret_due_q[0] <= cyc) begin
            dram_data_valid_in = 1'b1;
            dram_data_in       = blk_of(ret_addr_q.pop_front());
            void'(ret_due_q.pop_front());
        end else if (spurious) begin
            dram_data_valid_in = 1'b1;
            dram_data_in       = '1;
            spurious           = 0;
        end else begin
            dram_data_valid_in = 1'b0;
            dram_data_in       = '0;
        end

        if (prev_wait) begin
            check_int("cmd_hold_valid", int'(dram_cmd_valid_out), 1);
            check_int("cmd_hold_addr", int'(dram_cmd_addr_out), int'(prev_addr));
        end
        prev_wait = dram_cmd_valid_out && !dram_cmd_rdy_in;
        prev_addr = dram_cmd_addr_out;

        if (dram_cmd_valid_out && !saw_valid) begin
            saw_valid       = 1;
            first_valid_cyc = cyc;
        end
        if (req_go && ref_info_rdy_out) begin
            req_go  = 0;
            req_cyc = cyc;
        end
        if (dram_cmd_valid_out && dram_cmd_rdy_in) begin
            if (exp_addr_q.size() == 0) begin
                check_int("cmd_unexpected", int'(dram_cmd_valid_out), 0);
            end else begin
                check_int("cmd_addr", int'(dram_cmd_addr_out), int'(exp_addr_q.pop_front()));
            end
            lat = int'($urandom_range(lat_max, lat_min));
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            ret_addr_q.push_back(dram_cmd_addr_out);
            ret_due_q.push_back(due);
            last_cmd_addr = dram_cmd_addr_out;
            n_cmd++;
            inflight++;
        end
        if (ref_seq_block_valid_out && ref_seq_block_rdy_in) begin
            if (exp_blk_q.size() == 0) begin
                check_int("blk_unexpected", int'(ref_seq_block_valid_out), 0);
            end else begin
                check_vec("blk_data", ref_seq_block_out, blk_of(exp_blk_q.pop_front()));
            end
            n_blk++;
            inflight--;
        end
        // Blocks claimed but not yet consumed can never exceed the buffer.
        if (inflight > int'(DEPTH)) check_int("inflight_bound", inflight, int'(DEPTH));
        if (ref_done_out) begin
            n_done++;
            done_cyc = cyc;
        end
    endtask

    task automatic start_req(input logic [24:0] addr, input int len);
        logic [24:0] a;
        for (int i = 0; i < len; i++) begin
            a = addr + 25'(i);
            exp_addr_q.push_back(a);
            exp_blk_q.push_back(a);
        end
        req_addr  = addr;
        req_len   = 25'(len);
        req_go    = 1;
        saw_valid = 0;
        n_cmd     = 0;
        n_blk     = 0;
        n_done    = 0;
        req_cyc   = -1;
        done_cyc  = -1;
    endtask

    task automatic wait_done();
        int budget = 0;
        while (n_done == 0 && budget < 3000) begin
            tick();
            budget++;
        end
        if (n_done == 0) check_int("done_timeout", int'(ref_done_out), 1);
        repeat (3) tick();
    endtask

    task automatic finish_req(input int len, input logic [24:0] exp_last);
        check_int("cmd_count", n_cmd, len);
        check_int("blk_count", n_blk, len);
        check_int("done_count", n_done, 1);
        check_int("exp_addr_left", exp_addr_q.size(), 0);
        check_int("exp_blk_left", exp_blk_q.size(), 0);
        check_int("idle_rdy", int'(ref_info_rdy_out), 1);
        check_int("idle_cmd_valid", int'(dram_cmd_valid_out), 0);
        if (len > 0) begin
            check_int("last_cmd_addr", int'(last_cmd_addr), int'(exp_last));
            check_int("first_cmd_latency", first_valid_cyc, req_cyc + 1);
        end else begin
            check_int("zero_len_done_cycle", done_cyc, req_cyc + 1);
        end
    endtask

    task automatic clear_model();
        exp_addr_q.delete();
        exp_blk_q.delete();
        ret_addr_q.delete();
        ret_due_q.delete();
        inflight  = 0;
        last_due  = 0;
        prev_wait = 0;
        req_go    = 0;
        eng_hold  = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_int({tag, "_info_rdy"}, int'(ref_info_rdy_out), 1);
        check_int({tag, "_cmd_valid"}, int'(dram_cmd_valid_out), 0);
        check_int({tag, "_cmd_addr"}, int'(dram_cmd_addr_out), 0);
        check_int({tag, "_blk_valid"}, int'(ref_seq_block_valid_out), 0);
        check_vec({tag, "_blk"}, ref_seq_block_out, '0);
        check_int({tag, "_done"}, int'(ref_done_out), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[7];
        logic [24:0] ra;
        int          rl;

        rst                  = 1'b1;
        ref_addr_in          = '0;
        ref_length_in        = '0;
        ref_info_valid_in    = 1'b0;
        dram_cmd_rdy_in      = 1'b0;
        dram_data_in         = '0;
        dram_data_valid_in   = 1'b0;
        ref_seq_block_rdy_in = 1'b0;

        tbl[0] = '{25'h0000100, 3, 100, 100, 2, 2, 25'h0000102};
        tbl[1] = '{25'h1FFFFFF, 2, 100, 100, 1, 3, 25'h0000000};
        tbl[2] = '{25'h00ABCDE, 6, 50, 50, 1, 4, 25'h00ABCE3};
        tbl[3] = '{25'h1FFFFFD, 5, 70, 30, 2, 6, 25'h0000001};
        tbl[4] = '{25'h0000020, 1, 100, 100, 1, 1, 25'h0000020};
        tbl[5] = '{25'h0001234, 9, 100, 60, 1, 2, 25'h000123C};
        tbl[6] = '{25'h0000055, 0, 100, 100, 1, 1, 25'h0000000};

        #2;
        check_reset_outputs("rst_init");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Vector table
        for (int t = 0; t < 7; t++) begin
            cmd_pct = tbl[t].cmd_pct;
            eng_pct = tbl[t].eng_pct;
            lat_min = tbl[t].lmin;
            lat_max = tbl[t].lmax;
            start_req(tbl[t].addr, tbl[t].len);
            wait_done();
            finish_req(tbl[t].len, tbl[t].exp_last);
        end

        // Stray return beat while idle is dropped
        spurious = 1;
        tick();
        tick();
        check_int("stray_beat_dropped", int'(ref_seq_block_valid_out), 0);

        // Engine stalled: only DEPTH commands may go out, then the rest follow
        cmd_pct  = 100;
        lat_min  = 2;
        lat_max  = 2;
        eng_hold = 1;
        start_req(25'h0000400, 8);
        repeat (30) tick();
        check_int("stall_cmd_count", n_cmd, int'(DEPTH));
        check_int("stall_cmd_valid", int'(dram_cmd_valid_out), 0);
        check_int("stall_blk_valid", int'(ref_seq_block_valid_out), 1);
        eng_hold = 0;
        eng_pct  = 100;
        wait_done();
        finish_req(8, 25'h0000407);

        // Push, pop and command accept on the same edge with two blocks buffered
        lat_min  = 1;
        lat_max  = 1;
        eng_hold = 1;
        start_req(25'h0000600, 8);
        repeat (4) tick();
        check_int("triple_setup_cmds", n_cmd, 3);
        eng_hold = 0;
        tick();
        check_int("triple_data_valid", int'(dram_data_valid_in), 1);
        check_int("triple_blk_valid", int'(ref_seq_block_valid_out), 1);
        check_int("triple_cmds", n_cmd, 4);
        check_int("triple_pops", n_blk, 1);
        tick();
        check_int("triple_after_blk_valid", int'(ref_seq_block_valid_out), 1);
        check_int("triple_after_cmd_valid", int'(dram_cmd_valid_out), 1);
        wait_done();
        finish_req(8, 25'h0000607);

        // Reset in the middle of issuing, with two blocks buffered
        eng_hold = 1;
        start_req(25'h0000800, 8);
        repeat (3) tick();
        check_int("beat_not_early", int'(ref_seq_block_valid_out), 0);
        tick();
        check_int("beat_next_cycle", int'(ref_seq_block_valid_out), 1);
        check_vec("beat_next_cycle_data", ref_seq_block_out, blk_of(25'h0000800));
        @(negedge clk);
        rst                = 1'b1;
        dram_data_valid_in = 1'b0;
        ref_info_valid_in  = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cmd_pct = 80;
        eng_pct = 80;
        lat_max = 3;
        start_req(25'h0000900, 4);
        wait_done();
        finish_req(4, 25'h0000903);

        // Randomized requests against the model
        for (int r = 0; r < 25; r++) begin
            ra = ($urandom_range(2) == 0) ? 25'h1FFFFFF - 25'($urandom_range(3))
                                          : 25'($urandom);
            rl = int'($urandom_range(10));
            cmd_pct = int'($urandom_range(100, 30));
            eng_pct = int'($urandom_range(100, 30));
            lat_min = int'($urandom_range(3, 1));
            lat_max = lat_min + int'($urandom_range(3));
            start_req(ra, rl);
            wait_done();
            finish_req(rl, ra + 25'(rl) - 25'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
